keyboard_matrix: RTL

Holds the 10-column × 8-row PET keyboard matrix and answers the PET's column-select scan with row data. Key state is written through a staged register interface and made visible atomically on commit, so the PET never scans a half-updated matrix. Sits between the host register bridge (upstream) and the PIA1 port B row-input path (downstream). Also exports the committed matrix for diagnostics.

---
 rtl/keyboard_matrix_pkg.sv | 16 +
 rtl/keyboard_ghost_sweep.sv | 51 +++++
 rtl/keyboard_matrix.sv | 112 +++++++++++
 3 files changed

// File: rtl/keyboard_matrix_pkg.sv
// Shared types and sizes for the PET keyboard matrix block and its ghost sweep.
package keyboard_matrix_pkg;

    localparam int KBD_COLS = 10;
    localparam int KBD_ROWS = 8;

    typedef logic [KBD_ROWS-1:0] kbd_col_t;
    typedef kbd_col_t [KBD_COLS-1:0] kbd_matrix_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COPY  = 2'd1,
        SWEEP = 2'd2
    } kbd_commit_state_t;

endpackage

// File: rtl/keyboard_ghost_sweep.sv
// Walks the commit snapshot one column per cycle and builds the one-level ghost
// image of the matrix; the finished image is installed together with done_o.
module keyboard_ghost_sweep
    import keyboard_matrix_pkg::*;
(
    input  logic                               clk_sys_i,
    input  logic                               reset_i,
    input  logic                               sweep_en_i,
    input  logic [KBD_COLS-1:0][KBD_ROWS-1:0]  snapshot_i,
    output logic [KBD_COLS-1:0][KBD_ROWS-1:0]  ghost_o,
    output logic                               done_o
);

    logic [3:0]  col_cnt_q;
    kbd_matrix_t work_q;
    kbd_matrix_t ghost_q;
    kbd_col_t    ghost_col;

    // A column shares a ghost with every column that has a pressed key on a common row.
    always_comb begin
        ghost_col = '1;
        for (int k = 0; k < KBD_COLS; k++) begin
            if ((snapshot_i[k] | snapshot_i[col_cnt_q]) != '1)
                ghost_col = ghost_col & snapshot_i[k];
        end
    end

    assign done_o  = sweep_en_i && (col_cnt_q == 4'(KBD_COLS - 1));
    assign ghost_o = ghost_q;

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            col_cnt_q <= '0;
            work_q    <= '1;
            ghost_q   <= '1;
        end else begin
            if (sweep_en_i && !done_o)
                col_cnt_q <= col_cnt_q + 4'd1;
            else
                col_cnt_q <= '0;
            if (sweep_en_i)
                work_q[col_cnt_q] <= ghost_col;
            // The last column is still combinational here, so merge it on install.
            if (done_o) begin
                for (int i = 0; i < KBD_COLS; i++)
                    ghost_q[i] <= (4'(i) == col_cnt_q) ? ghost_col : work_q[i];
            end
        end
    end

endmodule

// File: rtl/keyboard_matrix.sv
// PET keyboard matrix: staged host writes, atomic commit, registered row lookup.
// Define KEYBOARD_MATRIX_GHOST_EN to add the ghost sweep and ghosted row data.
//
// state | meaning
// IDLE  | no commit in flight (without ghosting, also hosts the install cycle)
// COPY  | snapshot <= shadow
// SWEEP | ghost sweep over the snapshot; last column is the install cycle
module keyboard_matrix
    import keyboard_matrix_pkg::*;
(
    input  logic                               clk_sys_i,
    input  logic                               reset_i,
    input  logic [3:0]                         wr_addr_i,
    input  logic [KBD_ROWS-1:0]                wr_data_i,
    input  logic                               wr_strobe_i,
    output logic                               wr_ack_o,
    input  logic                               commit_i,
    output logic                               busy_o,
    input  logic [3:0]                         col_i,
    output logic [KBD_ROWS-1:0]                row_o,
    output logic [KBD_COLS-1:0][KBD_ROWS-1:0]  matrix_o,
    output logic                               any_key_o
);

    kbd_commit_state_t state_q, state_d;
    logic              pending_q, pending_d;
    kbd_matrix_t       shadow_q;
    kbd_matrix_t       snapshot_q;
    kbd_matrix_t       active_q;
    kbd_matrix_t       eff;
    logic              final_step;

`ifdef KEYBOARD_MATRIX_GHOST_EN
    kbd_matrix_t ghost;
    logic        sweep_done;

    keyboard_ghost_sweep u_ghost_sweep (
        .clk_sys_i  (clk_sys_i),
        .reset_i    (reset_i),
        .sweep_en_i (state_q == SWEEP),
        .snapshot_i (snapshot_q),
        .ghost_o    (ghost),
        .done_o     (sweep_done)
    );

    assign final_step = sweep_done;
    assign eff        = ghost;
    assign busy_o     = (state_q != IDLE);
`else
    logic install_q;

    // Install runs the cycle after COPY so active picks up the fresh snapshot.
    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i)
            install_q <= 1'b0;
        else
            install_q <= (state_q == COPY);
    end

    assign final_step = install_q;
    assign eff        = active_q;
    assign busy_o     = (state_q != IDLE) || install_q;
`endif

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (final_step)
            pending_d = 1'b0;
        else if (commit_i && busy_o)
            pending_d = 1'b1;

        case (state_q)
            IDLE:  if (commit_i || (final_step && pending_q)) state_d = COPY;
`ifdef KEYBOARD_MATRIX_GHOST_EN
            COPY:  state_d = SWEEP;
            SWEEP: if (sweep_done) state_d = (pending_q || commit_i) ? COPY : IDLE;
`else
            COPY:  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            shadow_q   <= '1;
            snapshot_q <= '1;
            active_q   <= '1;
            wr_ack_o   <= 1'b0;
            row_o      <= '1;
            any_key_o  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            wr_ack_o  <= wr_strobe_i;
            if (wr_strobe_i && (wr_addr_i < 4'(KBD_COLS)))
                shadow_q[wr_addr_i] <= wr_data_i;
            if (state_q == COPY)
                snapshot_q <= shadow_q;
            if (final_step)
                active_q <= snapshot_q;
            row_o     <= (col_i < 4'(KBD_COLS)) ? eff[col_i] : '1;
            any_key_o <= ~&active_q;
        end
    end

    assign matrix_o = active_q;

endmodule
